spi_device: RTL and testbench

SPI responder (device-side) block: the far end of the SPI link driven by the system's SPI host controller. Oversamples externally supplied `sck_i`, `csn_i` and `sdi_i` on the system clock and shifts received bytes into an RX queue. In the same transfer, it shifts bytes from a TX holding register out on `sdo_o`. Used for board-level loopback tests and as a bring-up peer for the host controller; supports all four CPOL/CPHA modes, MSB first, 8-bit frames.

---
 rtl/spi_device.sv | 167 ++++++++++++++++
 tb/tb_spi_device.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_device : SPI responder, oversampled SCK/CSN/SDI, TX holding register,
// RX queue (RxDepth-entry FIFO when SPI_DEVICE_RX_FIFO_EN is defined).
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
module spi_device #(
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter int RxDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sck_i,
  input  logic       csn_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sdo_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       tx_underrun_o,
  output logic       rx_overrun_o
);

  if (RxDepth < 2 || (RxDepth & (RxDepth - 1)) != 0) begin : g_depth_check
    $error("spi_device: RxDepth must be a power of two >= 2");
  end

  logic       sck_s1, sck_s2, sck_prev;
  logic       csn_s1, csn_s2;
  logic       sdi_s1, sdi_s2;
  logic       sel_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_data;
  logic       hold_full;

  logic       sel, sel_rise, lead, trail, sample, launch;
  logic       tx_load, byte_done, rx_full, rx_pop, rx_push;
  logic [7:0] rx_byte;

  // Edges seen in the select cycle itself are dropped; the host never clocks that early.
  assign sel       = ~csn_s2;
  assign sel_rise  = sel & ~sel_q;
  assign lead      = sel & ~sel_rise & (sck_prev == CPOL) & (sck_s2 != CPOL);
  assign trail     = sel & ~sel_rise & (sck_prev != CPOL) & (sck_s2 == CPOL);
  assign sample    = CPHA ? trail : lead;
  assign launch    = CPHA ? lead : trail;
  assign tx_load   = (sel_rise & ~CPHA) | (launch & (bit_cnt == 3'd0));
  assign byte_done = sample & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, sdi_s2};
  assign rx_pop    = rx_valid_o & rx_ready_i;
  assign rx_push   = byte_done & (~rx_full | rx_pop);

  assign sdo_o      = sel_q ? tx_shift[7] : 1'b1;
  assign sdo_oe_o   = sel_q;
  assign tx_ready_o = ~hold_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_s1        <= CPOL;
      sck_s2        <= CPOL;
      sck_prev      <= CPOL;
      csn_s1        <= 1'b1;
      csn_s2        <= 1'b1;
      sdi_s1        <= 1'b0;
      sdi_s2        <= 1'b0;
      sel_q         <= 1'b0;
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'd0;
      tx_shift      <= 8'd0;
      hold_data     <= 8'd0;
      hold_full     <= 1'b0;
      tx_underrun_o <= 1'b0;
      rx_overrun_o  <= 1'b0;
    end else begin
      sck_s1   <= sck_i;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      csn_s1   <= csn_i;
      csn_s2   <= csn_s1;
      sdi_s1   <= sdi_i;
      sdi_s2   <= sdi_s1;
      sel_q    <= sel;

      tx_underrun_o <= tx_load & ~hold_full;
      rx_overrun_o  <= byte_done & rx_full & ~rx_pop;

      if (!sel || sel_rise) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
      end else if (sample) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (tx_load) begin
        tx_shift <= hold_full ? hold_data : 8'hFF;
      end else if (launch) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // Accept only happens while empty, so a same-cycle load sees the old (empty) state.
      if (tx_valid_i && !hold_full) begin
        hold_data <= tx_data_i;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
    end
  end

`ifdef SPI_DEVICE_RX_FIFO_EN
  localparam int               PTR_W     = $clog2(RxDepth);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(RxDepth);

  logic [7:0]       mem [RxDepth];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;

  assign rx_full    = (count == DEPTH_CNT);
  assign rx_valid_o = (count != '0);
  assign rx_data_o  = mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RxDepth; i++) mem[i] <= 8'd0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (rx_push) begin
        mem[wptr] <= rx_byte;
        wptr      <= wptr + PTR_W'(1);
      end
      if (rx_pop) rptr <= rptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(rx_push) - (PTR_W + 1)'(rx_pop);
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_hold_v;

  assign rx_full    = rx_hold_v;
  assign rx_valid_o = rx_hold_v;
  assign rx_data_o  = rx_hold;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_hold   <= 8'd0;
      rx_hold_v <= 1'b0;
    end else if (rx_push) begin
      rx_hold   <= rx_byte;
      rx_hold_v <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_v <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_device.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spi_device: four responders (one per SPI mode) driven by a behavioural host,
// RX bytes checked by a scoreboard monitor, TX bytes and pulses by a queue model.
module tb_spi_device;
  localparam int H = 40;
`ifdef SPI_DEVICE_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck[4], csn[4], sdi[4], sdo[4], oe[4];
  logic       txv[4], txr[4], rxv[4], rxr[4], und[4], ovr[4];
  logic [7:0] txd[4], rxd[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_device #(.CPOL((g & 2) != 0), .CPHA((g & 1) != 0), .RxDepth(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .sck_i(sck[g]), .csn_i(csn[g]), .sdi_i(sdi[g]),
      .sdo_o(sdo[g]), .sdo_oe_o(oe[g]), .tx_data_i(txd[g]), .tx_valid_i(txv[g]),
      .tx_ready_o(txr[g]), .rx_data_o(rxd[g]), .rx_valid_o(rxv[g]), .rx_ready_i(rxr[g]),
      .tx_underrun_o(und[g]), .rx_overrun_o(ovr[g]));
  end

  int         n_chk = 0, n_pass = 0;
  logic [7:0] exp_rx[$];
  int         exp_ovr;
  int         und_cnt[4], ovr_cnt[4];
  logic       und_prev[4], ovr_prev[4];
  logic       hold_rx = 1'b0;
  logic [7:0] host_tx[8], host_rx[8], prov_tx[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  // Scoreboard monitor: every DUT pop is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 4; m++) begin
        if (rxv[m] && rxr[m]) begin
          if (exp_rx.size() == 0) begin
            n_chk++;
            $display("FAIL rx_extra_pop: got %02h expected no byte (mode %0d)", rxd[m], m);
          end else begin
            chk("rx_data", rxd[m], exp_rx.pop_front());
          end
        end
        if (und[m]) begin und_cnt[m]++; chk("underrun_width", und_prev[m], 1'b0); end
        if (ovr[m]) begin ovr_cnt[m]++; chk("overrun_width", ovr_prev[m], 1'b0); end
        und_prev[m] = und[m];
        ovr_prev[m] = ovr[m];
      end
    end
  end

  initial begin
    for (int m = 0; m < 4; m++) rxr[m] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 4; m++) rxr[m] = hold_rx ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic give_tx(input int m, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!txr[m] && t < 2000) begin @(negedge clk); t++; end
    if (!txr[m]) begin fail("tx_ready_timeout"); return; end
    txd[m] = b;
    txv[m] = 1'b1;
    @(posedge clk);
    #1 txv[m] = 1'b0;
  endtask

  // One byte (or its first nb bits) as the host sees it; the expected RX byte is
  // queued at the moment its last bit is sampled.
  task automatic host_bits(input int m, input int b, input int nb);
    logic       cpol, cpha;
    logic [7:0] r;
    cpol = (m & 2) != 0;
    cpha = (m & 1) != 0;
    r = 8'd0;
    for (int i = 7; i > 7 - nb; i--) begin
      if (!cpha) begin
        sdi[m] = host_tx[b][i];
        #(H);
        r = {r[6:0], sdo[m]};
        sck[m] = ~cpol;
        if (i == 0 && nb == 8) begin
          if (exp_rx.size() < CAP) exp_rx.push_back(host_tx[b]); else exp_ovr++;
        end
        #(H);
        sck[m] = cpol;
      end else begin
        #(H);
        sck[m] = ~cpol;
        sdi[m] = host_tx[b][i];
        #(H);
        r = {r[6:0], sdo[m]};
        sck[m] = cpol;
        if (i == 0 && nb == 8) begin
          if (exp_rx.size() < CAP) exp_rx.push_back(host_tx[b]); else exp_ovr++;
        end
      end
    end
    host_rx[b] = r;
  endtask

  // One CSN-low session of nbytes; the last one may be cut short to last_bits.
  // k bytes are offered to the TX holding register (first before select, rest on demand).
  task automatic session(input int m, input int nbytes, input int last_bits, input int k);
    int         cpha, loads, u0, o0, uexp;
    logic [7:0] q[$];
    logic [7:0] v;
    cpha  = m & 1;
    loads = cpha ? nbytes : ((last_bits == 8) ? nbytes + 1 : nbytes);
    u0 = und_cnt[m];
    o0 = ovr_cnt[m];
    exp_ovr = 0;
    uexp = 0;
    for (int j = 0; j < k; j++) q.push_back(prov_tx[j]);
    if (k > 0) give_tx(m, prov_tx[0]);
    @(posedge clk);
    #2;
    csn[m] = 1'b0;
    #60;
    chk("sdo_oe_selected", oe[m], 1'b1);
    chk("tx_ready_at_select", txr[m], (cpha == 0 || k == 0));
    fork
      for (int j = 1; j < k; j++) give_tx(m, prov_tx[j]);
      for (int b = 0; b < nbytes; b++) host_bits(m, b, (b == nbytes - 1) ? last_bits : 8);
    join
    #(H);
    csn[m] = 1'b1;
    sdi[m] = 1'b0;
    repeat (8) @(negedge clk);
    chk("sdo_oe_idle", oe[m], 1'b0);
    chk("sdo_idle", sdo[m], 1'b1);
    for (int l = 0; l < loads; l++) begin
      if (q.size() > 0) v = q.pop_front();
      else begin v = 8'hFF; uexp++; end
      if (l < nbytes && !(l == nbytes - 1 && last_bits != 8)) chk("host_rx", host_rx[l], v);
    end
    chk("underrun_count", und_cnt[m] - u0, uexp);
    chk("overrun_count", ovr_cnt[m] - o0, exp_ovr);
  endtask

  task automatic drain(input int m);
    int t = 0;
    while (exp_rx.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    if (exp_rx.size() != 0) fail("rx_drain_timeout");
    repeat (4) @(negedge clk);
    chk("rx_empty", rxv[m], 1'b0);
    exp_rx.delete();
  endtask

  task automatic reset_test(input int m);
    host_tx[0] = 8'($urandom);
    give_tx(m, 8'($urandom));
    @(posedge clk);
    #2;
    csn[m] = 1'b0;
    #60;
    fork
      give_tx(m, 8'($urandom));
      host_bits(m, 0, 3);
    join
    chk("tx_held_before_reset", txr[m], 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sdo", sdo[m], 1'b1);
    chk("rst_sdo_oe", oe[m], 1'b0);
    chk("rst_tx_ready", txr[m], 1'b1);
    chk("rst_rx_valid", rxv[m], 1'b0);
    chk("rst_rx_data", rxd[m], 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #(H);
    csn[m] = 1'b1;
    sdi[m] = 1'b0;
    repeat (10) @(negedge clk);
    host_tx[0] = 8'($urandom);
    prov_tx[0] = 8'($urandom);
    session(m, 1, 8, 1);
    drain(m);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sck[m] = (m & 2) != 0;
      csn[m] = 1'b1;
      sdi[m] = 1'b0;
      txv[m] = 1'b0;
      txd[m] = 8'd0;
      und_cnt[m] = 0;
      ovr_cnt[m] = 0;
      und_prev[m] = 1'b0;
      ovr_prev[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk("reset_sdo", sdo[m], 1'b1);
      chk("reset_sdo_oe", oe[m], 1'b0);
      chk("reset_tx_ready", txr[m], 1'b1);
      chk("reset_rx_valid", rxv[m], 1'b0);
      chk("reset_rx_data", rxd[m], 8'h00);
      chk("reset_underrun", und[m], 1'b0);
      chk("reset_overrun", ovr[m], 1'b0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0 loopback.
    host_tx[0] = 8'h3C;
    prov_tx[0] = 8'hA5;
    session(0, 1, 8, 1);
    drain(0);

    // Back-to-back two bytes in every mode.
    for (int m = 0; m < 4; m++) begin
      host_tx[0] = 8'h81; host_tx[1] = 8'h7E;
      prov_tx[0] = 8'h12; prov_tx[1] = 8'h34;
      session(m, 2, 8, 2);
      drain(m);
    end

    // Random traffic, including partially refilled holding register.
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 4; m++) begin
        n = $urandom_range(1, 3);
        k = $urandom_range(0, n);
        for (int j = 0; j < n; j++) begin
          host_tx[j] = 8'($urandom);
          prov_tx[j] = 8'($urandom);
        end
        session(m, n, 8, k);
        drain(m);
      end
    end

    // Underrun: nothing offered.
    for (int m = 0; m < 4; m++) begin
      host_tx[0] = 8'($urandom);
      session(m, 1, 8, 0);
      drain(m);
    end

    // Overrun: consumer stalled, one byte more than the queue holds.
    for (int m = 0; m < 4; m += 3) begin
      hold_rx = 1'b1;
      repeat (2) @(negedge clk);
      for (int j = 0; j <= CAP; j++) host_tx[j] = 8'($urandom);
      session(m, CAP + 1, 8, 0);
      chk("overrun_rx_valid", rxv[m], 1'b1);
      chk("overrun_head", rxd[m], exp_rx[0]);
      hold_rx = 1'b0;
      drain(m);
    end

    // Abort after 5 bits, then a full byte.
    for (int m = 0; m < 4; m++) begin
      host_tx[0] = 8'hF0;
      prov_tx[0] = 8'($urandom);
      session(m, 1, 5, 1);
      chk("abort_no_push", rxv[m], 1'b0);
      host_tx[0] = 8'h0F;
      prov_tx[0] = 8'($urandom);
      session(m, 1, 8, 1);
      drain(m);
    end

    // Asynchronous reset mid-byte, then a clean transfer.
    for (int m = 0; m < 4; m++) reset_test(m);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
